// File: rtl/result_bcd_converter.sv
// Sequential 16-bit binary to 5-digit BCD converter (double dabble, one bit per clock)
// with sign, overflow flag and leading-zero mask for a result display.
module result_bcd_converter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] value_in,
    input  logic        negative_in,
    output logic [19:0] bcd_out,
    output logic [4:0]  digit_valid,
    output logic        sign_out,
    output logic        overflow,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [19:0] scratch_q, scratch_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ovf_cap_q, ovf_cap_d;
    logic        neg_cap_q, neg_cap_d;
    logic [19:0] bcd_q, bcd_d;
    logic [4:0]  dv_q, dv_d;
    logic        sign_q, sign_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;

    logic [19:0] adjusted;
    logic [19:0] scratch_shifted;
    logic [15:0] shift_shifted;
    logic [4:0]  dv_final;
    logic        nz_acc;

    // One double-dabble step: digits are always <= 9 here, so +3 never carries out of a nibble.
    always_comb begin
        adjusted = scratch_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        scratch_shifted = {adjusted[18:0], shift_q[15]};
        shift_shifted   = {shift_q[14:0], 1'b0};
    end

    always_comb begin
        dv_final = '0;
        nz_acc   = 1'b0;
        for (int unsigned k = 0; k < 5; k++) begin
            nz_acc            = nz_acc | (|scratch_shifted[4*(4-k) +: 4]);
            dv_final[4-k]     = nz_acc;
        end
        dv_final[0] = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        ovf_cap_d = ovf_cap_q;
        neg_cap_d = neg_cap_q;
        bcd_d     = bcd_q;
        dv_d      = dv_q;
        sign_d    = sign_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            // The DONE->IDLE edge doubles as the IDLE sampling edge, so a request
            // is taken at the earliest one cycle after the done pulse begins.
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start) begin
                    shift_d   = value_in[15:0];
                    ovf_cap_d = |value_in[31:16];
                    neg_cap_d = negative_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = scratch_shifted;
                shift_d   = shift_shifted;
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    ovf_d   = ovf_cap_q;
                    sign_d  = neg_cap_q & (|scratch_shifted);
                    bcd_d   = ovf_cap_q ? '0 : scratch_shifted;
                    dv_d    = ovf_cap_q ? 5'b00001 : dv_final;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            ovf_cap_q <= 1'b0;
            neg_cap_q <= 1'b0;
            bcd_q     <= '0;
            dv_q      <= 5'b00001;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            ovf_cap_q <= ovf_cap_d;
            neg_cap_q <= neg_cap_d;
            bcd_q     <= bcd_d;
            dv_q      <= dv_d;
            sign_q    <= sign_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_valid = dv_q;
    assign sign_out    = sign_q;
    assign overflow    = ovf_q;
    assign busy        = (state_q == SHIFT);
    assign done        = done_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: expected results queued at request time,
// popped and compared on each done pulse; latency and reset behaviour checked per task.
`timescale 1ns/1ps
module tb_result_bcd_converter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value_in = '0;
    logic        negative_in = 1'b0;
    logic [19:0] bcd_out;
    logic [4:0]  digit_valid;
    logic        sign_out;
    logic        overflow;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [19:0] bcd;
        logic [4:0]  dv;
        logic        sign;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    result_bcd_converter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .value_in    (value_in),
        .negative_in (negative_in),
        .bcd_out     (bcd_out),
        .digit_valid (digit_valid),
        .sign_out    (sign_out),
        .overflow    (overflow),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Reference: decimal digits by repeated division, mask scanned from the top digit.
    function automatic exp_t model(input logic [31:0] v, input logic n);
        exp_t e;
        int   tmp;
        logic nz;
        e   = '0;
        tmp = int'(v[15:0]);
        for (int i = 0; i < 5; i++) begin
            e.bcd[4*i +: 4] = 4'(tmp % 10);
            tmp = tmp / 10;
        end
        nz = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            nz = nz | (e.bcd[4*i +: 4] != 4'd0);
            e.dv[i] = nz;
        end
        e.dv[0] = 1'b1;
        e.sign  = n && (v[15:0] != 16'd0);
        e.ovf   = |v[31:16];
        if (e.ovf) begin
            e.bcd = '0;
            e.dv  = 5'b00001;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_done: done=1 with no request outstanding, required none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_vec++;
                if (bcd_out !== e.bcd) begin
                    n_err++; $display("FAIL bcd_out: got %05h, required %05h", bcd_out, e.bcd);
                end
                n_vec++;
                if (digit_valid !== e.dv) begin
                    n_err++; $display("FAIL digit_valid: got %05b, required %05b", digit_valid, e.dv);
                end
                n_vec++;
                if (sign_out !== e.sign) begin
                    n_err++; $display("FAIL sign_out: got %b, required %b", sign_out, e.sign);
                end
                n_vec++;
                if (overflow !== e.ovf) begin
                    n_err++; $display("FAIL overflow: got %b, required %b", overflow, e.ovf);
                end
            end
        end
    end

    task automatic run_conv(input logic [31:0] v, input logic n, input string name);
        int lat;
        int bcnt;
        lat  = 0;
        bcnt = 0;
        @(negedge clk);
        value_in    = v;
        negative_in = n;
        start       = 1'b1;
        sb.push_back(model(v, n));
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        n_vec++;
        if (lat !== 17) begin
            n_err++; $display("FAIL %s_latency: done seen %0d negedges after request, required 17 (0=timeout)", name, lat);
        end
        n_vec++;
        if (bcnt !== 16) begin
            n_err++; $display("FAIL %s_busy_cycles: got %0d, required 16", name, bcnt);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL %s_done_width: done=%b busy=%b one cycle later, required 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        #23;
        n_vec++;
        if (bcd_out !== 20'h00000 || digit_valid !== 5'b00001) begin
            n_err++; $display("FAIL reset_digits: bcd=%05h dv=%05b, required 00000 00001", bcd_out, digit_valid);
        end
        n_vec++;
        if ({sign_out, overflow, busy, done} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: sign/ovf/busy/done=%04b, required 0000", {sign_out, overflow, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        run_conv(32'd0, 1'b1, "neg_zero");
        run_conv(32'd65535, 1'b0, "max");
        run_conv(32'd1234, 1'b1, "neg_1234");
        run_conv(32'h0001_0005, 1'b0, "overflow");
        run_conv(32'd100, 1'b1, "neg_100");
    endtask

    task automatic test_hold();
        run_conv(32'd65535, 1'b0, "hold");
        start    = 1'b0;
        value_in = 32'd321;
        repeat (5) @(negedge clk);
        n_vec++;
        if (bcd_out !== 20'h65535 || digit_valid !== 5'b11111 || overflow !== 1'b0) begin
            n_err++; $display("FAIL hold: bcd=%05h dv=%05b ovf=%b, required 65535 11111 0", bcd_out, digit_valid, overflow);
        end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        lat1 = 0;
        lat2 = 0;
        @(negedge clk);
        value_in    = 32'd42;
        negative_in = 1'b0;
        start       = 1'b1;
        sb.push_back(model(32'd42, 1'b0));
        sb.push_back(model(32'd907, 1'b0));
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            value_in = 32'd907;
            if (done) begin
                lat1 = k;
                break;
            end
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat2 = k;
                break;
            end
        end
        start = 1'b0;
        n_vec++;
        if (lat1 !== 17) begin
            n_err++; $display("FAIL b2b_first_latency: got %0d, required 17", lat1);
        end
        n_vec++;
        if (lat2 !== 17) begin
            n_err++; $display("FAIL b2b_second_latency: got %0d, required 17", lat2);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            n_err++; $display("FAIL b2b_idle: busy=%b pending=%0d, required 0 0", busy, sb.size());
        end
    endtask

    task automatic test_reset_abort();
        int dcnt;
        dcnt = 0;
        @(negedge clk);
        value_in    = 32'd999;
        negative_in = 1'b1;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL abort_busy_before: got %b, required 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (bcd_out !== 20'h00000 || digit_valid !== 5'b00001 || {sign_out, overflow, busy, done} !== 4'b0000) begin
            n_err++; $display("FAIL abort_async: bcd=%05h dv=%05b flags=%04b, required 00000 00001 0000",
                              bcd_out, digit_valid, {sign_out, overflow, busy, done});
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        n_vec++;
        if (dcnt !== 0) begin
            n_err++; $display("FAIL abort_no_done: %0d active cycles after reset, required 0", dcnt);
        end
        run_conv(32'd7, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_reset_abort();
        repeat (3) @(negedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: %0d results never produced, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/result_bcd_converter.md
RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

Interface
REQ-001 The block SHALL have no parameters; the magnitude width is fixed at 16 bits and the output width at 5 BCD digits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  conversion request, sampled on the rising edge of clk.
REQ-005 value_in  input  32  unsigned result magnitude from the arithmetic stage; bits [31:16] are expected to be zero.
REQ-006 negative_in  input  1  sign flag from the arithmetic stage; 1 means the result is negative.
REQ-007 bcd_out  output  20  five BCD digits, with digit4 in [19:16] (most significant) and digit0 in [3:0].
REQ-008 digit_valid  output  5  leading-zero mask, one bit per digit.
REQ-009 sign_out  output  1  registered display sign.
REQ-010 overflow  output  1  1 when value_in[31:16] was non-zero at capture.
REQ-011 busy  output  1  high while a conversion is in progress.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have three states, IDLE, SHIFT and DONE, and SHALL power up and reset to IDLE.
REQ-014 IDLE: a clock edge with start=1 SHALL perform all of the following:
- capture value_in[15:0] into a 16-bit shift register;
- capture overflow = |value_in[31:16];
- capture the sign;
- clear the 20-bit BCD scratch register and the 5-bit iteration counter;
- move the FSM to SHIFT.
REQ-015 SHIFT: each edge SHALL perform one double-dabble iteration, in this order:
- add 3 to every scratch digit that is >= 5;
- shift {scratch, shift register} left by 1;
- increment the counter.
REQ-016 SHIFT SHALL execute exactly 16 iterations; on the 16th edge the FSM SHALL load bcd_out, digit_valid and sign_out from the final values, set done=1 and move to DONE.
REQ-017 DONE SHALL last one cycle; the next edge SHALL clear done and return the FSM to IDLE.
REQ-018 Latency: when start is sampled at edge N, busy SHALL be 1 from N+1 through N+16, and done SHALL be 1 only between edges N+16 and N+17.
REQ-019 start SHALL be ignored in SHIFT and in DONE; a new request is accepted at edge N+17 at the earliest.
REQ-020 Between completions, bcd_out, digit_valid, sign_out and overflow SHALL hold their last loaded values.
REQ-021 Overflow handling:
- the conversion SHALL run on bits [15:0] only, with unchanged latency;
- overflow SHALL be 1 and bcd_out SHALL be 0x00000 for the whole result-hold period.
REQ-022 Sign rule: sign_out = captured negative_in AND (converted magnitude != 0); negative zero SHALL display as positive.
REQ-023 Leading-zero mask:
- digit_valid[k] SHALL be 1 if digit k or any higher-order digit is non-zero;
- digit_valid[0] SHALL always be 1;
- when overflow=1, digit_valid SHALL be 5'b00001.
REQ-024 Every BCD digit loaded into bcd_out SHALL be in the range 0..9; the maximum input 65535 SHALL fit without loss.
REQ-025 No arithmetic result SHALL be truncated; internal adders SHALL be 4 bits per digit, and a carry out of a digit cannot occur because digits are always <= 9 before the add-3 step.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock edge, force the following:
- FSM to IDLE;
- bcd_out=0, digit_valid=5'b00001;
- sign_out=0, overflow=0, busy=0, done=0;
- counter and scratch registers to 0.
REQ-027 Assertion of reset during SHIFT SHALL abort the conversion with no done pulse; after release the block SHALL accept a new start on the first edge.
REQ-028 Deassertion of rst_n SHALL be synchronised externally; the block SHALL take no action on the release edge other than the normal IDLE sampling of start.

Verification
REQ-029 value_in=0, negative_in=1, start pulse -> at N+16: bcd_out=0x00000, digit_valid=00001, sign_out=0, done pulse for 1 cycle.
REQ-030 value_in=65535 -> bcd_out=0x65535, digit_valid=11111, overflow=0; busy high for exactly 16 cycles.
REQ-031 value_in=1234, negative_in=1 -> bcd_out=0x01234, digit_valid=01111, sign_out=1.
REQ-032 value_in=0x0001_0005 -> overflow=1, bcd_out=0x00000, digit_valid=00001, and the done latency is still 16 cycles.
REQ-033 start held high continuously over two conversions (values 42, then 907) -> the second capture occurs at N+17; outputs 0x00042 then 0x00907; the start pulses applied during busy have no effect.
REQ-034 rst_n pulsed low at iteration 8 of converting 999 -> outputs are at reset values at once and no done pulse occurs; a following start with value 7 yields 0x00007 after 16 cycles.
